// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard logic and the pipeline registers.
//   hz_state_e      : hazard controller state (RUN / MWAIT / ERR)
//   REG_ZERO        : architectural $zero register address
//   *_CTRL_W        : control-bundle widths carried by the pipeline registers
//   reg_dep         : true when a real (non-$zero) destination feeds a source
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control bundles carried by the pipeline registers.
    localparam int EX_CTRL_W  = 4;  // regdst, alusrc, aluop[1:0]
    localparam int MEM_CTRL_W = 3;  // memread, memwrite, branch
    localparam int WB_CTRL_W  = 2;  // regwrite, memtoreg
    localparam int IDEX_CTRL_W  = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
    localparam int EXMEM_CTRL_W = MEM_CTRL_W + WB_CTRL_W;
    localparam int MEMWB_CTRL_W = WB_CTRL_W;

    // A write to $zero is discarded, so it never creates a dependency.
    function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// -----------------------------------------------------------------------------
// hazard_lu_detect
// Purely combinational load-use compare: flags when the load sitting in EX
// writes a register that the instruction in ID reads. Shared with the
// forwarding unit.
// Ports:
//   memread   in  : EX-stage instruction is a load
//   load_rt   in  : load destination register
//   src_rs    in  : RS of the instruction in ID
//   src_rt    in  : RT of the instruction in ID
//   uses_rt   in  : instruction in ID actually reads RT
//   hit       out : load-use dependency present
// -----------------------------------------------------------------------------
module hazard_lu_detect
    import pipe_pkg::*;
(
    input  logic       memread,
    input  logic [4:0] load_rt,
    input  logic [4:0] src_rs,
    input  logic [4:0] src_rt,
    input  logic       uses_rt,
    output logic       hit
);

    assign hit = memread &
                 (reg_dep(load_rt, src_rs) | (uses_rt & reg_dep(load_rt, src_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Generates hold/bubble/flush controls for the PC, IF_ID, ID_EX, EX_MEM and
// MEM_WB registers. Handles multi-cycle data-memory waits (with a timeout that
// latches a sticky error), load-use hazards and taken-branch flushes, with
// priority ERR > memory stall > load-use > branch flush.
//
// Optional feature: define HAZARD_STATS_EN to add saturating 32-bit cycle
// counters for memory stalls, load-use stalls and IF_ID flushes.
//
// Ports:
//   clk_i, rst_i              : clock, synchronous active-low reset
//   ifid_rsaddr_i/rtaddr_i    : source registers of the instruction in ID
//   ifid_uses_rt_i            : ID instruction reads RT
//   idex_memread_i/rtaddr_i   : load in EX and its destination
//   branch_taken_i            : branch resolved taken in ID
//   mem_req_i, dmem_ack_i     : data-memory access in MEM and its completion
//   pc/ifid/idex/exmem_stall_o: register holds
//   ifid_flush_o              : load NOP into IF_ID
//   idex_bubble_o             : zero ID_EX control bits
//   memwb_bubble_o            : zero MEM_WB regwrite
//   err_o                     : sticky memory-timeout error
//   stat_*_o (optional)       : event cycle counters
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ifid_rsaddr_i,
    input  logic [4:0] ifid_rtaddr_i,
    input  logic       ifid_uses_rt_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rtaddr_i,
    input  logic       branch_taken_i,
    input  logic       mem_req_i,
    input  logic       dmem_ack_i,
    output logic       pc_stall_o,
    output logic       ifid_stall_o,
    output logic       ifid_flush_o,
    output logic       idex_stall_o,
    output logic       idex_bubble_o,
    output logic       exmem_stall_o,
    output logic       memwb_bubble_o,
    output logic       err_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_mem_stall_o,
    output logic [31:0] stat_lu_stall_o,
    output logic [31:0] stat_flush_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic lu_hit;
    logic mstall;
    logic lu_stall;
    logic flush;
    logic in_err;

    hazard_lu_detect u_lu (
        .memread (idex_memread_i),
        .load_rt (idex_rtaddr_i),
        .src_rs  (ifid_rsaddr_i),
        .src_rt  (ifid_rtaddr_i),
        .uses_rt (ifid_uses_rt_i),
        .hit     (lu_hit)
    );

    // Priority resolution: each lower-priority event is masked by all above.
    assign in_err   = (state_q == ERR);
    assign mstall   = ~in_err & mem_req_i & ~dmem_ack_i;
    assign lu_stall = ~in_err & ~mstall & lu_hit;
    assign flush    = ~in_err & ~mstall & ~lu_hit & branch_taken_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mstall) begin
                    state_d = MWAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            MWAIT: begin
                // Ack or a withdrawn request both end the wait.
                if (dmem_ack_i || !mem_req_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // All outputs are held low while reset is asserted.
    always_comb begin
        pc_stall_o     = 1'b0;
        ifid_stall_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_stall_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_stall_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        err_o          = 1'b0;
        if (rst_i) begin
            pc_stall_o     = in_err | mstall | lu_stall;
            ifid_stall_o   = in_err | mstall | lu_stall;
            ifid_flush_o   = flush;
            idex_stall_o   = in_err | mstall;
            idex_bubble_o  = lu_stall;
            exmem_stall_o  = in_err | mstall;
            memwb_bubble_o = in_err | mstall;
            err_o          = err_q;
        end
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    logic [31:0] stat_mem_q, stat_lu_q, stat_flush_q;

    // Event terms are already masked in ERR, so error cycles are not counted.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_mem_q   <= '0;
            stat_lu_q    <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_mem_q   <= sat_inc32(stat_mem_q, mstall);
            stat_lu_q    <= sat_inc32(stat_lu_q, lu_stall);
            stat_flush_q <= sat_inc32(stat_flush_q, flush);
        end
    end

    assign stat_mem_stall_o = rst_i ? stat_mem_q   : 32'd0;
    assign stat_lu_stall_o  = rst_i ? stat_lu_q    : 32'd0;
    assign stat_flush_o     = rst_i ? stat_flush_q : 32'd0;
`endif

endmodule
